// File: rtl/ladybug_input_pkg.sv
// Shared constants for the Lady Bug input stage.
//   KEY_*  : 9-bit {extended, scan} codes. Arrow compares ignore bit 8.
//   JB_*   : bit positions in the MiSTer joystick word.
//   coin_state_t : coin pulse FSM states.
package ladybug_input_pkg;

  localparam logic [8:0] KEY_UP     = 9'h075;
  localparam logic [8:0] KEY_DOWN   = 9'h072;
  localparam logic [8:0] KEY_LEFT   = 9'h06B;
  localparam logic [8:0] KEY_RIGHT  = 9'h074;
  localparam logic [8:0] KEY_FIRE   = 9'h014;
  localparam logic [8:0] KEY_BOMB   = 9'h029;
  localparam logic [8:0] KEY_START1 = 9'h005;
  localparam logic [8:0] KEY_START2 = 9'h006;

  localparam int JB_RIGHT  = 0;
  localparam int JB_LEFT   = 1;
  localparam int JB_DOWN   = 2;
  localparam int JB_UP     = 3;
  localparam int JB_START1 = 4;
  localparam int JB_START2 = 5;
  localparam int JB_FIRE   = 6;
  localparam int JB_BOMB   = 7;

  typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_state_t;

  // Arrows are reachable both from the plain and the E0-extended keypad.
  function automatic logic arrow_hit(input logic [8:0] code, input logic [8:0] key);
    return code[7:0] == key[7:0];
  endfunction

endpackage

// File: rtl/ladybug_coin_pulse.sv
// Coin pulse generator: a rising edge on start gives COIN_PULSE cycles of
// coin, then COIN_GAP cycles during which new edges are ignored.
//   clk_sys, reset : clock, synchronous active-high reset
//   start          : combined start1 | start2 level
//   coin           : registered, active-high coin request
module ladybug_coin_pulse
  import ladybug_input_pkg::*;
#(
  parameter int COIN_PULSE = 400000,
  parameter int COIN_GAP   = 800000,
  parameter int CNT_W      = 21
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic start,
  output logic coin
);

  coin_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic             start_prev;
  logic             trig;

  assign trig = start & ~start_prev;

  always_ff @(posedge clk_sys) begin
    // start_prev tracks start in every state (and is primed on reset), so a
    // start still held when the FSM returns to IDLE cannot retrigger.
    start_prev <= start;
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      coin  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (trig) begin
          state <= PULSE;
          cnt   <= CNT_W'(COIN_PULSE - 1);
          coin  <= 1'b1;
        end
        PULSE: if (cnt == '0) begin
          state <= GAP;
          cnt   <= CNT_W'(COIN_GAP - 1);
          coin  <= 1'b0;
        end else begin
          cnt <= cnt - 1'b1;
        end
        GAP: if (cnt == '0) state <= IDLE;
             else           cnt   <= cnt - 1'b1;
        default: begin
          state <= IDLE;
          coin  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ladybug_input_ctrl.sv
// Lady Bug input stage: PS/2 keys and two joysticks merged into the core's
// active-low button buses, with optional Horz remap and a shaped coin pulse.
//   clk_sys, reset       : clock, synchronous active-high reset
//   ps2_key[64:0]        : toggle, filter bits, F0/E0 prefixes, scan code
//   joystick_0/1[15:0]   : R L D U start1 start2 fire bomb in bits 0..7
//   rotate               : 1 = Horz orientation
//   but_*_s[1:0]         : registered, active-low button buses
module ladybug_input_ctrl
  import ladybug_input_pkg::*;
#(
  parameter int COIN_PULSE = 400000,
  parameter int COIN_GAP   = 800000,
  parameter int CNT_W      = 21
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [64:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        rotate,
  output logic [1:0]  but_coin_s,
  output logic [1:0]  but_fire_s,
  output logic [1:0]  but_bomb_s,
  output logic [1:0]  but_tilt_s,
  output logic [1:0]  but_select_s,
  output logic [1:0]  but_up_s,
  output logic [1:0]  but_down_s,
  output logic [1:0]  but_left_s,
  output logic [1:0]  but_right_s
);

  logic       old_tog, key_evt, pressed, extended;
  logic [8:0] code;
  logic       k_up, k_down, k_left, k_right, k_fire, k_bomb, k_start1, k_start2;
  logic [15:0] joy;
  logic       up, down, left, right, fire, bomb, start1, start2;
  logic       o_up, o_down, o_left, o_right;
  logic       coin;
  logic       unused_joy;

  // Key decode. Non-zero upper bits mark PRNSCR/PAUSE sequences; forcing the
  // code to 0 makes them miss every mapping.
  always_comb begin
    key_evt  = ps2_key[64] != old_tog;
    pressed  = ps2_key[15:8] != 8'hF0;
    extended = pressed ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
    code     = (ps2_key[63:24] != '0) ? 9'h000 : {extended, ps2_key[7:0]};
  end

  always_ff @(posedge clk_sys) begin
    old_tog <= ps2_key[64];
    if (reset) begin
      {k_up, k_down, k_left, k_right} <= '0;
      {k_fire, k_bomb, k_start1, k_start2} <= '0;
    end else if (key_evt) begin
      if (arrow_hit(code, KEY_UP))    k_up     <= pressed;
      if (arrow_hit(code, KEY_DOWN))  k_down   <= pressed;
      if (arrow_hit(code, KEY_LEFT))  k_left   <= pressed;
      if (arrow_hit(code, KEY_RIGHT)) k_right  <= pressed;
      if (code == KEY_FIRE)           k_fire   <= pressed;
      if (code == KEY_BOMB)           k_bomb   <= pressed;
      if (code == KEY_START1)         k_start1 <= pressed;
      if (code == KEY_START2)         k_start2 <= pressed;
    end
  end

  assign joy        = joystick_0 | joystick_1;
  assign unused_joy = ^joy[15:8];

  assign up     = k_up     | joy[JB_UP];
  assign down   = k_down   | joy[JB_DOWN];
  assign left   = k_left   | joy[JB_LEFT];
  assign right  = k_right  | joy[JB_RIGHT];
  assign fire   = k_fire   | joy[JB_FIRE];
  assign bomb   = k_bomb   | joy[JB_BOMB];
  assign start1 = k_start1 | joy[JB_START1];
  assign start2 = k_start2 | joy[JB_START2];

  // Horz orientation rotates the stick a quarter turn.
  assign o_up    = rotate ? left  : up;
  assign o_down  = rotate ? right : down;
  assign o_left  = rotate ? down  : left;
  assign o_right = rotate ? up    : right;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      but_fire_s   <= 2'b11;
      but_bomb_s   <= 2'b11;
      but_tilt_s   <= 2'b11;
      but_select_s <= 2'b11;
      but_up_s     <= 2'b11;
      but_down_s   <= 2'b11;
      but_left_s   <= 2'b11;
      but_right_s  <= 2'b11;
    end else begin
      but_fire_s   <= {1'b1, ~fire};
      but_bomb_s   <= {1'b1, ~bomb};
      but_tilt_s   <= 2'b11;
      but_select_s <= {~start2, ~start1};
      but_up_s     <= {1'b1, ~o_up};
      but_down_s   <= {1'b1, ~o_down};
      but_left_s   <= {1'b1, ~o_left};
      but_right_s  <= {1'b1, ~o_right};
    end
  end

  ladybug_coin_pulse #(
    .COIN_PULSE (COIN_PULSE),
    .COIN_GAP   (COIN_GAP),
    .CNT_W      (CNT_W)
  ) u_coin (
    .clk_sys (clk_sys),
    .reset   (reset),
    .start   (start1 | start2),
    .coin    (coin)
  );

  // coin is already a flop output, so this bus is registered as well.
  assign but_coin_s = {1'b1, ~coin};

endmodule

// File: tb/tb_ladybug_input_ctrl.sv
// Directed bench for ladybug_input_ctrl with a short coin pulse (4) and gap (6).
module tb_ladybug_input_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [64:0] ps2_key;
  logic [15:0] joystick_0, joystick_1;
  logic        rotate;
  logic [1:0]  but_coin_s, but_fire_s, but_bomb_s, but_tilt_s, but_select_s;
  logic [1:0]  but_up_s, but_down_s, but_left_s, but_right_s;

  int  errors = 0;
  int  checks = 0;
  int  coin_cycles;
  logic tog = 1'b1;

  always #5 clk = ~clk;

  ladybug_input_ctrl #(.COIN_PULSE(4), .COIN_GAP(6), .CNT_W(4)) dut (
    .clk_sys(clk), .reset(reset), .ps2_key(ps2_key),
    .joystick_0(joystick_0), .joystick_1(joystick_1), .rotate(rotate),
    .but_coin_s(but_coin_s), .but_fire_s(but_fire_s), .but_bomb_s(but_bomb_s),
    .but_tilt_s(but_tilt_s), .but_select_s(but_select_s),
    .but_up_s(but_up_s), .but_down_s(but_down_s),
    .but_left_s(but_left_s), .but_right_s(but_right_s)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic key(input logic [7:0] b2, input logic [7:0] b1,
                     input logic [7:0] sc, input logic [39:0] hi);
    tog     = ~tog;
    ps2_key = {tog, hi, b2, b1, sc};
  endtask

  initial begin
    reset = 1'b1; rotate = 1'b0;
    ps2_key = {1'b1, 64'h0}; joystick_0 = 16'h0010; joystick_1 = 16'h0;

    // 1: reset with toggle high and start1 held
    repeat (3) step();
    chk("rst_coin", but_coin_s, 2'b11);
    chk("rst_fire", but_fire_s, 2'b11);
    chk("rst_bomb", but_bomb_s, 2'b11);
    chk("rst_tilt", but_tilt_s, 2'b11);
    chk("rst_sel", but_select_s, 2'b11);
    chk("rst_up", but_up_s, 2'b11);
    chk("rst_down", but_down_s, 2'b11);
    chk("rst_left", but_left_s, 2'b11);
    chk("rst_right", but_right_s, 2'b11);
    reset = 1'b0;
    step();
    chk("post_rst_up", but_up_s, 2'b11);
    chk("post_rst_sel", but_select_s, 2'b10);
    for (int i = 0; i < 8; i++) chk("post_rst_nocoin", but_coin_s, 2'b11);
    coin_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (but_coin_s[0] == 1'b0) coin_cycles++;
    end
    chk("post_rst_coin_cnt", coin_cycles, 0);
    joystick_0 = 16'h0;
    step();
    chk("sel_release", but_select_s, 2'b11);

    // 2: extended up press / release
    key(8'h00, 8'hE0, 8'h75, 40'h0);
    step();
    chk("up_lat1", but_up_s, 2'b11);
    step();
    chk("up_press", but_up_s, 2'b10);
    chk("up_down", but_down_s, 2'b11);
    chk("up_left", but_left_s, 2'b11);
    chk("up_right", but_right_s, 2'b11);
    key(8'hE0, 8'hF0, 8'h75, 40'h0);
    step();
    chk("up_rel_lat1", but_up_s, 2'b10);
    step();
    chk("up_release", but_up_s, 2'b11);

    // 3: rotate maps up to right
    rotate = 1'b1; joystick_1 = 16'h0008;
    step();
    chk("rot_right", but_right_s, 2'b10);
    chk("rot_up", but_up_s, 2'b11);
    joystick_1 = 16'h0; rotate = 1'b0;
    step();
    chk("rot_clear", but_right_s, 2'b11);

    // back-to-back key events
    key(8'h00, 8'h00, 8'h14, 40'h0);
    step();
    key(8'h00, 8'h00, 8'h29, 40'h0);
    step();
    chk("b2b_fire", but_fire_s, 2'b10);
    step();
    chk("b2b_bomb", but_bomb_s, 2'b10);
    key(8'h00, 8'hF0, 8'h14, 40'h0);
    step();
    key(8'h00, 8'hF0, 8'h29, 40'h0);
    step();
    step();
    chk("b2b_fire_rel", but_fire_s, 2'b11);
    chk("b2b_bomb_rel", but_bomb_s, 2'b11);

    // 4: single-cycle start1 -> 4-cycle pulse, press during gap ignored
    joystick_0 = 16'h0010;
    step();
    joystick_0 = 16'h0;
    chk("pulse_c0", but_coin_s, 2'b10);
    for (int i = 1; i < 4; i++) begin
      step();
      chk("pulse_cn", but_coin_s, 2'b10);
    end
    step();
    chk("pulse_end", but_coin_s, 2'b11);
    joystick_0 = 16'h0010;
    step();
    chk("gap_press", but_coin_s, 2'b11);
    joystick_0 = 16'h0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("gap_quiet", but_coin_s, 2'b11);
    end

    // 5: start2 held through pulse and gap
    joystick_1 = 16'h0020;
    step();
    chk("hold_sel", but_select_s, 2'b01);
    chk("hold_coin", but_coin_s, 2'b10);
    coin_cycles = 1;
    for (int i = 0; i < 15; i++) begin
      step();
      if (but_coin_s[0] == 1'b0) coin_cycles++;
    end
    chk("hold_coin_cnt", coin_cycles, 4);
    chk("hold_sel_end", but_select_s, 2'b01);
    joystick_1 = 16'h0;
    step();
    chk("hold_sel_rel", but_select_s, 2'b11);
    joystick_1 = 16'h0020;
    step();
    chk("repress_coin", but_coin_s, 2'b10);
    joystick_1 = 16'h0;
    repeat (12) step();

    // 6: filtered key, then reset mid-pulse
    key(8'h00, 8'h00, 8'h14, 40'h1);
    step();
    step();
    chk("filt_fire", but_fire_s, 2'b11);
    joystick_0 = 16'h0010;
    step();
    step();
    chk("mid_coin", but_coin_s, 2'b10);
    reset = 1'b1;
    step();
    chk("mid_rst_coin", but_coin_s, 2'b11);
    chk("mid_rst_sel", but_select_s, 2'b11);
    reset = 1'b0;
    coin_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (but_coin_s[0] == 1'b0) coin_cycles++;
    end
    chk("mid_rst_nocoin", coin_cycles, 0);
    joystick_0 = 16'h0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
